input_debouncer: RTL

Synchronises and debounces one asynchronous, bouncy level input, such as a push-button or external strobe, into a clean single-bit level on the system clock. It sits directly upstream of `edge_detector` and drives that block's `d` input. The downstream edge detector therefore sees exactly one transition per qualified input change, and no glitches or metastable samples.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_ff.sv | 31 +++
 rtl/input_debouncer.sv | 71 +++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer and related filters.
package debounce_pkg;

    // Filter state: STABLE when the synchronised input matches the output,
    // PEND while a differing level is being qualified.
    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_t;

    // Width of a counter that must represent 0 .. stable_cycles without wrapping.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Parameterised N-stage flop synchroniser for asynchronous inputs.
module sync_ff #(
    parameter int unsigned       WIDTH       = 1,
    parameter int unsigned       STAGES      = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw input through the flop chain; reset loads every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VALUE;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces one bouncy asynchronous level into a clean,
// registered level that changes only after STABLE_CYCLES consistent samples.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic pending
);

    localparam int unsigned          CNT_W    = cnt_width(STABLE_CYCLES);
    // cnt == CNT_LAST is the same test as cnt + 1 == STABLE_CYCLES, without
    // needing a wider intermediate.
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             dout_n;

    sync_ff #(
        .WIDTH       (1),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync)
    );

    // Next-state logic: count consecutive disagreements, commit on the last one,
    // and drop back to zero on any bounce-back to the current output level.
    always_comb begin
        state_n = STABLE;
        cnt_n   = '0;
        dout_n  = dout;
        if (sync != dout) begin
            if (cnt == CNT_LAST) begin
                dout_n = sync;
            end else begin
                cnt_n   = cnt + CNT_W'(1);
                state_n = PEND;
            end
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            dout  <= RESET_LEVEL;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
        end
    end

    assign pending = (state == PEND);

endmodule
